// File: rtl/addsub_stream_pkg.sv
// Shared types and constants for the addsub_stream block: join-state encoding,
// mode-word bit positions and the default setting-register address.
package addsub_stream_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN_A = 2'd1,
      ST_DRAIN_B = 2'd2
   } state_e;

   localparam int MODE_SAT  = 0;
   localparam int MODE_HALF = 1;
   localparam int MODE_SWAP = 2;
   localparam int MODE_W    = 3;

   localparam int SR_MODE_DEFAULT = 128;

endpackage

// File: rtl/addsub_stream_lane.sv
// Single signed component add/subtract with optional halving (floor) or
// saturation to WIDTH bits; wraps when neither is selected.
module addsub_lane #(
   parameter int WIDTH = 16
) (
   input  logic signed [WIDTH-1:0] x_i,
   input  logic signed [WIDTH-1:0] y_i,
   input  logic                    sub_i,
   input  logic                    half_i,
   input  logic                    sat_i,
   output logic signed [WIDTH-1:0] res_o
);

   localparam logic signed [WIDTH:0] MAX_V = {2'b00, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH:0] MIN_V = {2'b11, {(WIDTH-1){1'b0}}};

   function automatic logic signed [WIDTH-1:0] sat_f(input logic signed [WIDTH:0] v);
      if (v > MAX_V)      return MAX_V[WIDTH-1:0];
      else if (v < MIN_V) return MIN_V[WIDTH-1:0];
      else                return v[WIDTH-1:0];
   endfunction

   // A WIDTH+1 bit result halved always fits back in WIDTH bits.
   function automatic logic signed [WIDTH-1:0] half_f(input logic signed [WIDTH:0] v);
      logic signed [WIDTH:0] sh;
      sh = v >>> 1;
      return sh[WIDTH-1:0];
   endfunction

   logic signed [WIDTH:0] x_ext;
   logic signed [WIDTH:0] y_ext;
   logic signed [WIDTH:0] full;

   assign x_ext = {x_i[WIDTH-1], x_i};
   assign y_ext = {y_i[WIDTH-1], y_i};

   always_comb begin
      full = sub_i ? (x_ext - y_ext) : (x_ext + y_ext);
      if (half_i)     res_o = half_f(full);
      else if (sat_i) res_o = sat_f(full);
      else            res_o = full[WIDTH-1:0];
   end

endmodule

// File: rtl/addsub_stream.sv
// Joins two complex sample streams beat-for-beat and emits A+B and A-B on two
// independently back-pressured outputs, realigning packets of unequal length.
module addsub_stream
   import addsub_stream_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int SR_MODE   = SR_MODE_DEFAULT,
   parameter int CNT_WIDTH = 16
) (
   input  logic                   ce_clk,
   input  logic                   ce_rst,
   input  logic                   set_stb,
   input  logic [7:0]             set_addr,
   input  logic [31:0]            set_data,
   input  logic [2*WIDTH-1:0]     a_tdata,
   input  logic [127:0]           a_tuser,
   input  logic                   a_tlast,
   input  logic                   a_tvalid,
   output logic                   a_tready,
   input  logic [2*WIDTH-1:0]     b_tdata,
   input  logic                   b_tlast,
   input  logic                   b_tvalid,
   output logic                   b_tready,
   output logic [2*WIDTH-1:0]     sum_tdata,
   output logic [127:0]           sum_tuser,
   output logic                   sum_tlast,
   output logic                   sum_tvalid,
   input  logic                   sum_tready,
   output logic [2*WIDTH-1:0]     diff_tdata,
   output logic [127:0]           diff_tuser,
   output logic                   diff_tlast,
   output logic                   diff_tvalid,
   input  logic                   diff_tready,
   output logic [CNT_WIDTH-1:0]   mismatch_cnt
);

   localparam int         DW      = 2*WIDTH;
   localparam logic [7:0] SR_ADDR = 8'(SR_MODE);

   state_e                state_q, state_d;
   logic [MODE_W-1:0]     mode_cfg_q, mode_cfg_d;
   logic [MODE_W-1:0]     mode_act_q, mode_act_d;
   logic [MODE_W-1:0]     mode_use;
   logic                  first_q, first_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  sum_vld_q, sum_vld_d;
   logic                  diff_vld_q, diff_vld_d;
   logic [DW-1:0]         sum_data_q, diff_data_q;
   logic [127:0]          user_q;
   logic                  last_q;

   logic                  sum_free, diff_free, outs_free, join_w, out_last;

   logic signed [WIDTH-1:0] a_i, a_q, b_i, b_q;
   logic signed [WIDTH-1:0] dx_i, dx_q, dy_i, dy_q;
   logic signed [WIDTH-1:0] sum_i_r, sum_q_r, diff_i_r, diff_q_r;

   assign sum_free  = !sum_vld_q  || sum_tready;
   assign diff_free = !diff_vld_q || diff_tready;
   assign outs_free = sum_free && diff_free;
   assign join_w    = !ce_rst && (state_q == ST_RUN) && a_tvalid && b_tvalid && outs_free;
   assign out_last  = a_tlast || b_tlast;

   // The first beat of a packet uses the freshly configured mode; later beats
   // reuse the mode latched on that first beat.
   assign mode_use = first_q ? mode_cfg_q : mode_act_q;

   assign a_i = a_tdata[DW-1:WIDTH];
   assign a_q = a_tdata[WIDTH-1:0];
   assign b_i = b_tdata[DW-1:WIDTH];
   assign b_q = b_tdata[WIDTH-1:0];

   assign dx_i = mode_use[MODE_SWAP] ? b_i : a_i;
   assign dy_i = mode_use[MODE_SWAP] ? a_i : b_i;
   assign dx_q = mode_use[MODE_SWAP] ? b_q : a_q;
   assign dy_q = mode_use[MODE_SWAP] ? a_q : b_q;

   addsub_lane #(.WIDTH(WIDTH)) u_sum_i (
      .x_i(a_i), .y_i(b_i), .sub_i(1'b0),
      .half_i(mode_use[MODE_HALF]), .sat_i(mode_use[MODE_SAT]), .res_o(sum_i_r));
   addsub_lane #(.WIDTH(WIDTH)) u_sum_q (
      .x_i(a_q), .y_i(b_q), .sub_i(1'b0),
      .half_i(mode_use[MODE_HALF]), .sat_i(mode_use[MODE_SAT]), .res_o(sum_q_r));
   addsub_lane #(.WIDTH(WIDTH)) u_diff_i (
      .x_i(dx_i), .y_i(dy_i), .sub_i(1'b1),
      .half_i(mode_use[MODE_HALF]), .sat_i(mode_use[MODE_SAT]), .res_o(diff_i_r));
   addsub_lane #(.WIDTH(WIDTH)) u_diff_q (
      .x_i(dx_q), .y_i(dy_q), .sub_i(1'b1),
      .half_i(mode_use[MODE_HALF]), .sat_i(mode_use[MODE_SAT]), .res_o(diff_q_r));

   always_comb begin
      a_tready = 1'b0;
      b_tready = 1'b0;
      if (!ce_rst) begin
         case (state_q)
            ST_RUN: begin
               a_tready = b_tvalid && outs_free;
               b_tready = a_tvalid && outs_free;
            end
            ST_DRAIN_A: a_tready = 1'b1;
            ST_DRAIN_B: b_tready = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      mode_cfg_d = mode_cfg_q;
      mode_act_d = mode_act_q;
      first_d    = first_q;
      cnt_d      = cnt_q;
      sum_vld_d  = sum_vld_q  && !sum_tready;
      diff_vld_d = diff_vld_q && !diff_tready;

      if (set_stb && (set_addr == SR_ADDR))
         mode_cfg_d = set_data[MODE_W-1:0];

      case (state_q)
         ST_RUN: begin
            if (join_w) begin
               sum_vld_d  = 1'b1;
               diff_vld_d = 1'b1;
               first_d    = out_last;
               if (first_q)
                  mode_act_d = mode_cfg_q;
               if (a_tlast != b_tlast) begin
                  state_d = a_tlast ? ST_DRAIN_B : ST_DRAIN_A;
                  if (cnt_q != {CNT_WIDTH{1'b1}})
                     cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_DRAIN_A: if (a_tvalid && a_tlast) state_d = ST_RUN;
         ST_DRAIN_B: if (b_tvalid && b_tlast) state_d = ST_RUN;
         default:    state_d = ST_RUN;
      endcase
   end

   // Control registers
   always_ff @(posedge ce_clk) begin
      if (ce_rst) begin
         state_q    <= ST_RUN;
         mode_cfg_q <= '0;
         mode_act_q <= '0;
         first_q    <= 1'b1;
         cnt_q      <= '0;
         sum_vld_q  <= 1'b0;
         diff_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_cfg_q <= mode_cfg_d;
         mode_act_q <= mode_act_d;
         first_q    <= first_d;
         cnt_q      <= cnt_d;
         sum_vld_q  <= sum_vld_d;
         diff_vld_q <= diff_vld_d;
      end
   end

   // Output data registers: both outputs load together on a join
   always_ff @(posedge ce_clk) begin
      if (join_w) begin
         sum_data_q  <= {sum_i_r, sum_q_r};
         diff_data_q <= {diff_i_r, diff_q_r};
         user_q      <= a_tuser;
         last_q      <= out_last;
      end
   end

   assign sum_tdata    = sum_data_q;
   assign sum_tuser    = user_q;
   assign sum_tlast    = last_q;
   assign sum_tvalid   = sum_vld_q && !ce_rst;
   assign diff_tdata   = diff_data_q;
   assign diff_tuser   = user_q;
   assign diff_tlast   = last_q;
   assign diff_tvalid  = diff_vld_q && !ce_rst;
   assign mismatch_cnt = ce_rst ? '0 : cnt_q;

endmodule

// File: tb/tb_addsub_stream.sv
// Directed bench for addsub_stream: arithmetic modes, packet realignment,
// independent output backpressure and reset behaviour.
module tb_addsub_stream;

   logic         clk = 1'b0;
   logic         ce_rst;
   logic         set_stb;
   logic [7:0]   set_addr;
   logic [31:0]  set_data;
   logic [31:0]  a_tdata, b_tdata;
   logic [127:0] a_tuser;
   logic         a_tlast, a_tvalid, a_tready;
   logic         b_tlast, b_tvalid, b_tready;
   logic [31:0]  sum_tdata, diff_tdata;
   logic [127:0] sum_tuser, diff_tuser;
   logic         sum_tlast, sum_tvalid, sum_tready;
   logic         diff_tlast, diff_tvalid, diff_tready;
   logic [15:0]  mismatch_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   addsub_stream #(.WIDTH(16), .SR_MODE(128), .CNT_WIDTH(16)) dut (
      .ce_clk(clk), .ce_rst(ce_rst),
      .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .a_tdata(a_tdata), .a_tuser(a_tuser), .a_tlast(a_tlast),
      .a_tvalid(a_tvalid), .a_tready(a_tready),
      .b_tdata(b_tdata), .b_tlast(b_tlast), .b_tvalid(b_tvalid), .b_tready(b_tready),
      .sum_tdata(sum_tdata), .sum_tuser(sum_tuser), .sum_tlast(sum_tlast),
      .sum_tvalid(sum_tvalid), .sum_tready(sum_tready),
      .diff_tdata(diff_tdata), .diff_tuser(diff_tuser), .diff_tlast(diff_tlast),
      .diff_tvalid(diff_tvalid), .diff_tready(diff_tready),
      .mismatch_cnt(mismatch_cnt));

   function automatic logic [31:0] iq(input int i, input int q);
      logic [31:0] iv, qv;
      iv = i;
      qv = q;
      return {iv[15:0], qv[15:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_tvalid = 1'b0;
      b_tvalid = 1'b0;
      a_tlast  = 1'b0;
      b_tlast  = 1'b0;
   endtask

   task automatic set_mode(input logic [2:0] m);
      set_stb  = 1'b1;
      set_addr = 8'd128;
      set_data = {29'd0, m};
      tick();
      set_stb  = 1'b0;
      set_data = '0;
   endtask

   task automatic join_beat(input logic [31:0] a, input logic [31:0] b,
                            input logic al, input logic bl, input logic [127:0] u);
      a_tdata = a; b_tdata = b; a_tlast = al; b_tlast = bl; a_tuser = u;
      a_tvalid = 1'b1; b_tvalid = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_reset();
      ce_rst = 1'b1;
      a_tvalid = 1'b1; b_tvalid = 1'b1;
      repeat (3) tick();
      tests++; if (sum_tvalid !== 1'b0) begin fails++; $display("FAIL rst_sum_tvalid: got %b want 0", sum_tvalid); end
      tests++; if (diff_tvalid !== 1'b0) begin fails++; $display("FAIL rst_diff_tvalid: got %b want 0", diff_tvalid); end
      tests++; if (a_tready !== 1'b0) begin fails++; $display("FAIL rst_a_tready: got %b want 0", a_tready); end
      tests++; if (b_tready !== 1'b0) begin fails++; $display("FAIL rst_b_tready: got %b want 0", b_tready); end
      tests++; if (mismatch_cnt !== 16'd0) begin fails++; $display("FAIL rst_cnt: got %0d want 0", mismatch_cnt); end
      idle();
      ce_rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      a_tdata = iq(100, -5); b_tdata = iq(20, 7); a_tuser = 128'hCAFE_0001;
      a_tlast = 1'b1; b_tlast = 1'b1; a_tvalid = 1'b1; b_tvalid = 1'b1;
      #1;
      tests++; if (sum_tvalid !== 1'b0) begin fails++; $display("FAIL basic_pre_valid: got %b want 0", sum_tvalid); end
      tests++; if (a_tready !== 1'b1) begin fails++; $display("FAIL basic_a_tready: got %b want 1", a_tready); end
      tick();
      idle();
      tests++; if (sum_tvalid !== 1'b1 || diff_tvalid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b%b want 11", sum_tvalid, diff_tvalid); end
      tests++; if (sum_tdata !== iq(120, 2)) begin fails++; $display("FAIL basic_sum: got %h want %h", sum_tdata, iq(120, 2)); end
      tests++; if (diff_tdata !== iq(80, -12)) begin fails++; $display("FAIL basic_diff: got %h want %h", diff_tdata, iq(80, -12)); end
      tests++; if (sum_tuser !== 128'hCAFE_0001 || diff_tuser !== 128'hCAFE_0001) begin fails++; $display("FAIL basic_tuser: got %h want cafe0001", sum_tuser); end
      tests++; if (sum_tlast !== 1'b1) begin fails++; $display("FAIL basic_tlast: got %b want 1", sum_tlast); end
      tick();
      tests++; if (sum_tvalid !== 1'b0) begin fails++; $display("FAIL basic_consumed: got %b want 0", sum_tvalid); end
   endtask

   task automatic test_sat();
      set_mode(3'b001);
      join_beat(iq(32767, -32768), iq(1, 1), 1'b1, 1'b1, 128'h1);
      tests++; if (sum_tdata !== iq(32767, -32767)) begin fails++; $display("FAIL sat_sum: got %h want %h", sum_tdata, iq(32767, -32767)); end
      tests++; if (diff_tdata !== iq(32766, -32768)) begin fails++; $display("FAIL sat_diff: got %h want %h", diff_tdata, iq(32766, -32768)); end
      set_mode(3'b000);
      join_beat(iq(32767, -32768), iq(1, 1), 1'b1, 1'b1, 128'h2);
      tests++; if (sum_tdata !== iq(-32768, -32767)) begin fails++; $display("FAIL wrap_sum: got %h want %h", sum_tdata, iq(-32768, -32767)); end
      tests++; if (diff_tdata !== iq(32766, 32767)) begin fails++; $display("FAIL wrap_diff: got %h want %h", diff_tdata, iq(32766, 32767)); end
   endtask

   task automatic test_half_swap();
      set_mode(3'b010);
      join_beat(iq(3, -3), iq(0, 0), 1'b1, 1'b1, 128'h3);
      tests++; if (sum_tdata !== iq(1, -2)) begin fails++; $display("FAIL half_sum: got %h want %h", sum_tdata, iq(1, -2)); end
      set_mode(3'b100);
      join_beat(iq(5, 5), iq(2, 2), 1'b1, 1'b1, 128'h4);
      tests++; if (diff_tdata !== iq(-3, -3)) begin fails++; $display("FAIL swap_diff: got %h want %h", diff_tdata, iq(-3, -3)); end
      tests++; if (sum_tdata !== iq(7, 7)) begin fails++; $display("FAIL swap_sum: got %h want %h", sum_tdata, iq(7, 7)); end
      set_mode(3'b000);
   endtask

   task automatic test_mismatch();
      int ia = 0, ib = 0, nsum = 0, cyc = 0;
      logic ha, hb;
      while ((ia < 4 || ib < 6) && cyc < 40) begin
         a_tvalid = (ia < 4); a_tdata = iq(ia + 1, ia); a_tlast = (ia == 3); a_tuser = 128'(ia);
         b_tvalid = (ib < 6); b_tdata = iq(100, 2 * ib); b_tlast = (ib == 5);
         #1;
         ha = a_tvalid && a_tready;
         hb = b_tvalid && b_tready;
         @(posedge clk); #1;
         if (ha) ia++;
         if (hb) ib++;
         if (sum_tvalid) begin
            tests++; if (sum_tdata !== iq(nsum + 101, 3 * nsum)) begin fails++; $display("FAIL mm_sum%0d: got %h want %h", nsum, sum_tdata, iq(nsum + 101, 3 * nsum)); end
            tests++; if (sum_tlast !== (nsum == 3)) begin fails++; $display("FAIL mm_tlast%0d: got %b want %b", nsum, sum_tlast, (nsum == 3)); end
            nsum++;
         end
         cyc++;
      end
      idle();
      tests++; if (ia != 4 || ib != 6) begin fails++; $display("FAIL mm_consumed: got a=%0d b=%0d want a=4 b=6", ia, ib); end
      tests++; if (nsum != 4) begin fails++; $display("FAIL mm_out_beats: got %0d want 4", nsum); end
      tests++; if (mismatch_cnt !== 16'd1) begin fails++; $display("FAIL mm_cnt: got %0d want 1", mismatch_cnt); end
      tick();
      join_beat(iq(1, 2), iq(3, 4), 1'b1, 1'b1, 128'h5);
      tests++; if (sum_tvalid !== 1'b1 || sum_tdata !== iq(4, 6)) begin fails++; $display("FAIL mm_realign: got %b/%h want 1/%h", sum_tvalid, sum_tdata, iq(4, 6)); end
      tests++; if (mismatch_cnt !== 16'd1) begin fails++; $display("FAIL mm_cnt_after: got %0d want 1", mismatch_cnt); end
      tick();
   endtask

   task automatic test_backpressure();
      int ia = 0, ns = 0, nd = 0, nd_stall = 0, c = 0;
      logic hin, hs, hd;
      diff_tready = 1'b1;
      while ((ns < 3 || nd < 3) && c < 60) begin
         sum_tready = (c >= 11);
         a_tvalid = (ia < 3); b_tvalid = (ia < 3);
         a_tdata = iq(10 * ia + 1, ia); b_tdata = iq(ia, 1);
         a_tlast = (ia == 2); b_tlast = (ia == 2); a_tuser = 128'(ia);
         #1;
         hin = a_tvalid && a_tready && b_tvalid && b_tready;
         hs  = sum_tvalid && sum_tready;
         hd  = diff_tvalid && diff_tready;
         if (c >= 2 && c <= 10) begin
            tests++; if (sum_tvalid !== 1'b1 || sum_tdata !== iq(1, 1)) begin fails++; $display("FAIL bp_hold_c%0d: got %b/%h want 1/%h", c, sum_tvalid, sum_tdata, iq(1, 1)); end
            tests++; if (a_tready !== 1'b0) begin fails++; $display("FAIL bp_stall_c%0d: got %b want 0", c, a_tready); end
         end
         if (hd && c <= 10) nd_stall++;
         if (hs) begin
            tests++; if (sum_tdata !== iq(11 * ns + 1, ns + 1)) begin fails++; $display("FAIL bp_sum%0d: got %h want %h", ns, sum_tdata, iq(11 * ns + 1, ns + 1)); end
            ns++;
         end
         if (hd) begin
            tests++; if (diff_tdata !== iq(9 * nd + 1, nd - 1)) begin fails++; $display("FAIL bp_diff%0d: got %h want %h", nd, diff_tdata, iq(9 * nd + 1, nd - 1)); end
            nd++;
         end
         @(posedge clk); #1;
         if (hin) ia++;
         c++;
      end
      idle();
      sum_tready = 1'b1;
      tests++; if (nd_stall != 1) begin fails++; $display("FAIL bp_diff_during_stall: got %0d want 1", nd_stall); end
      tests++; if (ns != 3 || nd != 3) begin fails++; $display("FAIL bp_counts: got sum=%0d diff=%0d want 3/3", ns, nd); end
      tick();
      tests++; if (sum_tvalid !== 1'b0 || diff_tvalid !== 1'b0) begin fails++; $display("FAIL bp_no_dup: got %b%b want 00", sum_tvalid, diff_tvalid); end
   endtask

   task automatic test_mode_reset();
      join_beat(iq(10, 20), iq(0, 0), 1'b0, 1'b0, 128'h10);
      tests++; if (sum_tdata !== iq(10, 20)) begin fails++; $display("FAIL mr_beat0: got %h want %h", sum_tdata, iq(10, 20)); end
      set_mode(3'b010);
      join_beat(iq(10, 20), iq(0, 0), 1'b1, 1'b1, 128'h11);
      tests++; if (sum_tdata !== iq(10, 20)) begin fails++; $display("FAIL mr_midpkt: got %h want %h", sum_tdata, iq(10, 20)); end
      join_beat(iq(10, 20), iq(0, 0), 1'b0, 1'b0, 128'h12);
      tests++; if (sum_tdata !== iq(5, 10)) begin fails++; $display("FAIL mr_nextpkt: got %h want %h", sum_tdata, iq(5, 10)); end
      sum_tready = 1'b0;
      a_tdata = iq(7, 7); b_tdata = iq(1, 1); a_tvalid = 1'b1; b_tvalid = 1'b1;
      tick();
      tests++; if (a_tready !== 1'b0 || sum_tvalid !== 1'b1) begin fails++; $display("FAIL mr_stalled: got rdy=%b vld=%b want 0/1", a_tready, sum_tvalid); end
      ce_rst = 1'b1;
      idle();
      tick();
      tests++; if (sum_tvalid !== 1'b0 || diff_tvalid !== 1'b0) begin fails++; $display("FAIL mr_rst_valid: got %b%b want 00", sum_tvalid, diff_tvalid); end
      tests++; if (mismatch_cnt !== 16'd0) begin fails++; $display("FAIL mr_rst_cnt: got %0d want 0", mismatch_cnt); end
      ce_rst = 1'b0;
      sum_tready = 1'b1;
      tick();
      tests++; if (sum_tvalid !== 1'b0 || diff_tvalid !== 1'b0) begin fails++; $display("FAIL mr_post_valid: got %b%b want 00", sum_tvalid, diff_tvalid); end
      join_beat(iq(10, 20), iq(0, 0), 1'b1, 1'b1, 128'h13);
      tests++; if (sum_tvalid !== 1'b1 || sum_tdata !== iq(10, 20)) begin fails++; $display("FAIL mr_mode_cleared: got %b/%h want 1/%h", sum_tvalid, sum_tdata, iq(10, 20)); end
      tick();
   endtask

   initial begin
      ce_rst = 1'b1;
      set_stb = 1'b0; set_addr = '0; set_data = '0;
      a_tdata = '0; b_tdata = '0; a_tuser = '0;
      idle();
      sum_tready = 1'b1; diff_tready = 1'b1;
      test_reset();
      test_basic();
      test_sat();
      test_half_swap();
      test_mismatch();
      test_backpressure();
      test_mode_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/addsub_stream.md
ADDSUB_STREAM -- requirements
Module: addsub_stream

Interface
REQ-001 Parameter WIDTH, default 16: bits per I/Q component; sample = {I,Q}, 2*WIDTH bits.
REQ-002 Parameter SR_MODE, default 128: setting-register address of the mode word.
REQ-003 Parameter CNT_WIDTH, default 16: width of mismatch_cnt.
REQ-004 ce_clk  in  1  single clock; all logic synchronous to it.
REQ-005 ce_rst  in  1  reset: synchronous and active-high.
REQ-006 set_stb/set_addr/set_data  in  1/8/32  setting-register write port.
REQ-007 a_tdata/a_tuser/a_tlast/a_tvalid  in  2*WIDTH/128/1/1; a_tready out 1  operand A stream; tuser carries the CHDR header.
REQ-008 b_tdata/b_tlast/b_tvalid  in  2*WIDTH/1/1; b_tready out 1  operand B stream.
REQ-009 sum_tdata/sum_tuser/sum_tlast/sum_tvalid  out  2*WIDTH/128/1/1; sum_tready in 1  A+B.
REQ-010 diff_tdata/diff_tuser/diff_tlast/diff_tvalid  out  2*WIDTH/128/1/1; diff_tready in 1  A-B.
REQ-011 mismatch_cnt  out  CNT_WIDTH  count of packets with unequal A/B lengths.

Function
REQ-012 Mode word (set_data[2:0] at SR_MODE): bit0 SAT, bit1 HALF, bit2 SWAP; other addresses ignored.
REQ-013 Mode written mid-packet takes effect at the first beat of the next packet; active mode latched on each packet's first joined beat.
REQ-014 Join: a beat is consumed from A and B in the same cycle only when a_tvalid, b_tvalid, state RUN, and both output registers are empty or draining this cycle.
REQ-015 Latency: 1 cycle from join to sum_tvalid and diff_tvalid; full throughput of 1 beat/cycle when both outputs ready.
REQ-016 Outputs have independent backpressure: each output register holds until its own tready; the other output is not stalled while it is empty or draining.
REQ-017 Arithmetic per component, signed: computed at WIDTH+1 bits; SWAP makes diff = B-A.
REQ-018 HALF: result arithmetic-shifted right 1 (floor); cannot overflow.
REQ-019 HALF=0, SAT=1: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; SAT=0: wrap (keep low WIDTH bits).
REQ-020 sum_tuser and diff_tuser equal the a_tuser of the joined beat.
REQ-021 States RUN, DRAIN_A, DRAIN_B; reset to RUN.
REQ-022 RUN, joined beat with a_tlast=b_tlast: output tlast=that value; stay RUN.
REQ-023 RUN, joined beat with a_tlast=1, b_tlast=0: output tlast=1, mismatch_cnt+1, go DRAIN_B.
REQ-024 RUN, joined beat with b_tlast=1, a_tlast=0: output tlast=1, mismatch_cnt+1, go DRAIN_A.
REQ-025 DRAIN_x: x_tready=1, other tready=0, no outputs produced; beats discarded; return to RUN on the cycle an x beat with tlast is consumed.
REQ-026 mismatch_cnt saturates at all-ones.
REQ-027 tvalid never depends combinationally on tready; tdata/tuser/tlast stable while tvalid and not tready.

Reset
REQ-028 While ce_rst=1: sum_tvalid=diff_tvalid=0, a_tready=b_tready=0, mismatch_cnt=0, mode=0, state=RUN.
REQ-029 Reset mid-packet discards held output beats and partial packets; first beats after reset start new packets.

Structure
REQ-030 Package addsub_stream_pkg holds the state enum, mode bit indices, and default SR_MODE.
REQ-031 One sub-module, addsub_lane: single-component add/subtract with HALF/SAT handling; instantiated 4 times (sum I/Q, diff I/Q).

Verification
REQ-032 WIDTH=16, mode 0, A={100,-5}, B={20,7} -> sum {120,2}, diff {80,-12}, one cycle after join.
REQ-033 SAT=1, A={32767,-32768}, B={1,1} -> sum {32767,-32767}, diff {32766,-32768}; SAT=0 -> sum {-32768,-32767}.
REQ-034 HALF=1, A={3,-3}, B={0,0} -> sum {1,-2}; SWAP=1, A=5, B=2 -> diff -3.
REQ-035 A packet 4 beats, B 6 beats -> 4 output beats, tlast on 4th, B's 2 extra beats dropped, mismatch_cnt=1, next packet aligned.
REQ-036 sum_tready held 0 for 10 cycles, diff_tready=1 -> diff emits 1 beat, input stalls, sum data stable, no loss or duplication after release.
REQ-037 Mode write mid-packet, then ce_rst pulse during a stalled beat -> mode applies only from next packet; after reset all outputs invalid, counter 0.
